// File: rtl/cmd_exec_pkg.sv
// Shared types for the command executor: FSM states, the packed command record,
// modulation type codes and interval-length helpers.
package cmd_exec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_BLANK1,
        ST_PULSE,
        ST_GAP,
        ST_BLANK2,
        ST_REQ
    } exec_state_t;

    // 338 bits, start time in the top bits
    typedef struct packed {
        logic [63:0] time_start;
        logic [47:0] freq;
        logic [47:0] freq_step;
        logic [31:0] freq_rate;
        logic [15:0] n_impuls;
        logic [1:0]  imp_type;
        logic [31:0] ti;
        logic [31:0] tp;
        logic [31:0] tblank1;
        logic [31:0] tblank2;
    } cmd_t;

    localparam logic [1:0] TYPE_CW    = 2'd0;
    localparam logic [1:0] TYPE_CHIRP = 2'd1;
    localparam logic [1:0] TYPE_STEP  = 2'd2;

    function automatic logic [31:0] pulse_len(cmd_t c);
        return (c.ti == 32'd0) ? 32'd1 : c.ti;
    endfunction

    // A zero-length gap would merge impulses, so the gap is at least one cycle
    function automatic logic [31:0] gap_len(cmd_t c);
        return (c.tp > c.ti) ? (c.tp - c.ti) : 32'd1;
    endfunction

endpackage

// File: rtl/cmd_executor_freq_ramp.sv
// Frequency word generator: constant, intra-impulse chirp or per-impulse step,
// all arithmetic modulo 2^48.
module freq_ramp
    import cmd_exec_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        start,
    input  logic        first,
    input  logic        run,
    input  logic [47:0] base,
    input  logic [47:0] step,
    input  logic [31:0] rate,
    input  logic [1:0]  mode,
    output logic [47:0] freq
);

    logic [47:0]      freq_reg;
    logic [47:0]      next_imp_reg;
    logic [CNT_W-1:0] rate_cnt_reg;
    logic [CNT_W-1:0] rate_last;
    logic [47:0]      imp_freq;

    assign rate_last = CNT_W'((rate == 32'd0) ? 32'd0 : rate - 32'd1);
    // Stepped mode walks an accumulator one STEP per impulse; other modes restart at base
    assign imp_freq  = (mode == TYPE_STEP && !first) ? next_imp_reg : base;
    assign freq      = freq_reg;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            freq_reg     <= '0;
            next_imp_reg <= '0;
            rate_cnt_reg <= '0;
        end else if (start) begin
            freq_reg     <= imp_freq;
            next_imp_reg <= imp_freq + step;
            rate_cnt_reg <= '0;
        end else if (run && mode == TYPE_CHIRP) begin
            if (rate_cnt_reg >= rate_last) begin
                freq_reg     <= freq_reg + step;
                rate_cnt_reg <= '0;
            end else begin
                rate_cnt_reg <= rate_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmd_executor.sv
// Command executor: holds a command until its start time, plays the blank /
// impulse / gap sequence and then requests the next command from the writer.
module cmd_executor
    import cmd_exec_pkg::*;
#(
    parameter int REQ_LEN = 4,
    parameter int CNT_W   = 32
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic [63:0] TIME,
    input  logic        DATA_WR,
    input  logic [47:0] FREQ_z,
    input  logic [47:0] FREQ_STEP_z,
    input  logic [31:0] FREQ_RATE_z,
    input  logic [63:0] TIME_START_z,
    input  logic [15:0] N_impuls_z,
    input  logic [1:0]  TYPE_impulse_z,
    input  logic [31:0] Interval_Ti_z,
    input  logic [31:0] Interval_Tp_z,
    input  logic [31:0] Tblank1_z,
    input  logic [31:0] Tblank2_z,
    output logic        REQ_COMM,
    output logic        IMP,
    output logic        BLANK,
    output logic [47:0] FREQ_OUT,
    output logic        FREQ_EN,
    output logic        BUSY,
    output logic        LATE_ERR,
    output logic [15:0] PULSE_CNT
);

    exec_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    cmd_t             cmd_reg, cmd_next;
    cmd_t             shadow_reg, shadow_next;
    logic             pend_reg, pend_next;
    logic             req_load_reg, req_load_next;
    logic             late_reg, late_next;
    logic [15:0]      pulse_cnt_reg, pulse_cnt_next;
    logic             wr_prev_reg;
    logic             wr_rise;
    logic             timer_done;
    cmd_t             fields;

    assign fields = '{time_start: TIME_START_z, freq: FREQ_z, freq_step: FREQ_STEP_z,
                      freq_rate: FREQ_RATE_z, n_impuls: N_impuls_z, imp_type: TYPE_impulse_z,
                      ti: Interval_Ti_z, tp: Interval_Tp_z, tblank1: Tblank1_z,
                      tblank2: Tblank2_z};

    assign wr_rise    = DATA_WR & ~wr_prev_reg;
    assign timer_done = (cnt_reg == '0);

    // Down-counter preload for a state: its length minus one
    function automatic logic [CNT_W-1:0] reload_val(exec_state_t s, cmd_t c);
        logic [31:0] len;
        len = 32'd1;
        case (s)
            ST_BLANK1: len = c.tblank1;
            ST_PULSE:  len = pulse_len(c);
            ST_GAP:    len = gap_len(c);
            ST_BLANK2: len = c.tblank2;
            ST_REQ:    len = 32'(REQ_LEN);
            default:   len = 32'd1;
        endcase
        return CNT_W'(len - 32'd1);
    endfunction

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        cmd_next       = cmd_reg;
        shadow_next    = shadow_reg;
        pend_next      = pend_reg;
        req_load_next  = req_load_reg;
        late_next      = 1'b0;
        pulse_cnt_next = pulse_cnt_reg;

        case (state_reg)
            ST_IDLE, ST_ARMED: begin
                if (wr_rise) begin
                    cmd_next   = fields;
                    late_next  = (TIME_START_z <= TIME);
                    state_next = ST_ARMED;
                end else if (state_reg == ST_ARMED && TIME >= cmd_reg.time_start) begin
                    pulse_cnt_next = '0;
                    if (cmd_reg.n_impuls == 16'd0)
                        state_next = ST_REQ;
                    else if (cmd_reg.tblank1 != 32'd0)
                        state_next = ST_BLANK1;
                    else
                        state_next = ST_PULSE;
                end
            end
            ST_BLANK1: begin
                if (timer_done)
                    state_next = ST_PULSE;
            end
            ST_PULSE: begin
                if (timer_done) begin
                    pulse_cnt_next = pulse_cnt_reg + 16'd1;
                    if ((17'(pulse_cnt_reg) + 17'd1) < {1'b0, cmd_reg.n_impuls})
                        state_next = ST_GAP;
                    else if (cmd_reg.tblank2 != 32'd0)
                        state_next = ST_BLANK2;
                    else
                        state_next = ST_REQ;
                end
            end
            ST_GAP: begin
                if (timer_done)
                    state_next = ST_PULSE;
            end
            ST_BLANK2: begin
                if (timer_done)
                    state_next = ST_REQ;
            end
            ST_REQ: begin
                if (wr_rise) begin
                    cmd_next      = fields;
                    late_next     = (TIME_START_z <= TIME);
                    req_load_next = 1'b1;
                end
                if (timer_done) begin
                    req_load_next = 1'b0;
                    if (pend_reg) begin
                        cmd_next   = shadow_reg;
                        pend_next  = 1'b0;
                        late_next  = (shadow_reg.time_start <= TIME);
                        state_next = ST_ARMED;
                    end else if (req_load_reg || wr_rise) begin
                        state_next = ST_ARMED;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // A command arriving mid-sequence waits in the shadow until the request phase
        if (wr_rise && (state_reg == ST_BLANK1 || state_reg == ST_PULSE ||
                        state_reg == ST_GAP || state_reg == ST_BLANK2)) begin
            shadow_next = fields;
            pend_next   = 1'b1;
        end

        if (state_next != state_reg)
            cnt_next = reload_val(state_next, cmd_reg);
        else if (!timer_done)
            cnt_next = cnt_reg - 1'b1;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            cmd_reg       <= '0;
            shadow_reg    <= '0;
            pend_reg      <= 1'b0;
            req_load_reg  <= 1'b0;
            late_reg      <= 1'b0;
            pulse_cnt_reg <= '0;
            wr_prev_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            cmd_reg       <= cmd_next;
            shadow_reg    <= shadow_next;
            pend_reg      <= pend_next;
            req_load_reg  <= req_load_next;
            late_reg      <= late_next;
            pulse_cnt_reg <= pulse_cnt_next;
            wr_prev_reg   <= DATA_WR;
        end
    end

    logic ramp_start, ramp_first, ramp_run;

    // The word is loaded on the edge entering PULSE so it is valid on the first IMP cycle
    assign ramp_start = (state_next == ST_PULSE) && (state_reg != ST_PULSE);
    assign ramp_first = (state_reg != ST_GAP);
    assign ramp_run   = (state_reg == ST_PULSE) && (state_next == ST_PULSE);

    freq_ramp #(
        .CNT_W (CNT_W)
    ) u_freq_ramp (
        .CLK   (CLK),
        .rst_n (rst_n),
        .start (ramp_start),
        .first (ramp_first),
        .run   (ramp_run),
        .base  (cmd_reg.freq),
        .step  (cmd_reg.freq_step),
        .rate  (cmd_reg.freq_rate),
        .mode  (cmd_reg.imp_type),
        .freq  (FREQ_OUT)
    );

    assign IMP       = (state_reg == ST_PULSE);
    assign FREQ_EN   = IMP;
    assign BLANK     = (state_reg == ST_BLANK1) || (state_reg == ST_BLANK2);
    assign REQ_COMM  = (state_reg == ST_REQ);
    assign BUSY      = (state_reg != ST_IDLE);
    assign LATE_ERR  = late_reg;
    assign PULSE_CNT = pulse_cnt_reg;

endmodule

// File: doc/cmd_executor.md
Name: cmd_executor

Overview:
- Consumer end of the command-memory interface: receives the command selected by the command-memory writer on DATA_WR and holds it until system time reaches TIME_START.
- Then generates the pulse train (blanks, impulses, frequency word) and requests the next command via REQ_COMM.
- Sits between the command-memory writer and the DDS/TX gating logic, in the 48 MHz CLK domain.

Parameters:
- REQ_LEN, 4, REQ_COMM high duration in CLK cycles; must be >=3 for the writer's edge detector.
- CNT_W, 32, width of the Ti/Tp/Tblank/rate counters.

Ports:
- CLK  in  1  system clock, 48 MHz
- rst_n  in  1  asynchronous active-low reset
- TIME  in  64  current system time, in CLK ticks
- DATA_WR  in  1  command strobe from the writer; rising edge loads the command fields
- FREQ_z  in  48  start frequency word
- FREQ_STEP_z  in  48  frequency increment
- FREQ_RATE_z  in  32  cycles between increments
- TIME_START_z  in  64  start time
- N_impuls_z  in  16  impulse count
- TYPE_impulse_z  in  2  modulation type
- Interval_Ti_z  in  32  impulse width
- Interval_Tp_z  in  32  impulse period
- Tblank1_z  in  32  pre-blank length
- Tblank2_z  in  32  post-blank length
- REQ_COMM  out  1  next-command request, high for REQ_LEN cycles
- IMP  out  1  impulse gate
- BLANK  out  1  receiver blanking gate
- FREQ_OUT  out  48  current frequency word
- FREQ_EN  out  1  FREQ_OUT valid; equals IMP
- BUSY  out  1  high whenever state != IDLE
- LATE_ERR  out  1  one-cycle pulse: command loaded with TIME_START <= TIME
- PULSE_CNT  out  16  impulses completed in the current command

Behaviour:
- Reset: all outputs 0; state IDLE; pend=0.
- Command load:
  - DATA_WR rising edge is detected via a registered previous value, so a strobe longer than one cycle loads once.
  - In IDLE, ARMED or REQ: fields load into cmd registers. In IDLE/ARMED, go to ARMED (overwrite allowed). In REQ, go to ARMED when REQ completes.
  - In BLANK1/PULSE/GAP/BLANK2: fields load into the shadow register; pend=1; the active command continues.
- States: IDLE, ARMED, BLANK1, PULSE, GAP, BLANK2, REQ.
- ARMED:
  - Compare every cycle; leave ARMED the cycle after TIME >= cmd.TIME_START.
  - Entry target: BLANK1 if Tblank1 != 0, else PULSE.
  - If TIME_START <= TIME already on the load cycle, LATE_ERR pulses one cycle and the start is immediate.
  - SYS_TIME_UPDATE needs no special handling; the comparison is continuous.
- N_impuls=0: ARMED goes directly to REQ at start time; no IMP or BLANK.
- BLANK1: BLANK=1 for exactly Tblank1 cycles, then PULSE.
- PULSE:
  - IMP=1 for max(Ti,1) cycles.
  - On exit, PULSE_CNT increments. Next state is GAP if PULSE_CNT+1 < N, else BLANK2, or REQ if Tblank2 == 0.
- GAP:
  - IMP=0 for (Tp>Ti ? Tp-Ti : 1) cycles, then PULSE.
  - Resulting impulse period is max(Tp, Ti+1).
- BLANK2: BLANK=1 for Tblank2 cycles, then REQ.
- REQ:
  - REQ_COMM=1 for REQ_LEN cycles.
  - Then: if pend, shadow moves to cmd, pend=0, go ARMED (LATE check applies). Else if a load occurred during REQ, go ARMED. Else IDLE.
- Frequency, driven only while in PULSE:
  - TYPE 0: FREQ_OUT = FREQ constant.
  - TYPE 1 (intra-impulse chirp): FREQ_OUT = FREQ at each impulse start; +FREQ_STEP every FREQ_RATE cycles inside the impulse.
  - TYPE 2 (stepped): impulse k uses FREQ + k*FREQ_STEP.
  - TYPE 3: treated as TYPE 0.
  - FREQ_RATE=0 is treated as 1.
  - All additions are modulo 2^48.
  - Outside PULSE, FREQ_OUT holds its last value.
- PULSE_CNT clears on entry to BLANK1/PULSE from ARMED.
- Reset mid-operation: immediate return to reset values; pend discarded.

Decomposition:
- Package cmd_exec_pkg:
  - state enum exec_state_t;
  - struct cmd_t packed with all command fields, 338 bits, field order TIME_START first;
  - TYPE constants TYPE_CW=0, TYPE_CHIRP=1, TYPE_STEP=2.
- Sub-module freq_ramp:
  - inputs: start, base, step, rate, mode;
  - output: freq word;
  - owns the rate counter and the 48-bit accumulator.

Test Plan:
- Load cmd TIME_START=1000, N=2, Ti=10, Tp=30, Tblank1=5, Tblank2=7, TYPE=0 at TIME=900 -> timing:
  - BLANK high cycles 1001-1005;
  - IMP high 10 cycles starting at 1006, and again at 1036;
  - BLANK high 7 cycles after the second impulse gap-free;
  - REQ_COMM high 4 cycles;
  - PULSE_CNT=2; BUSY drops; LATE_ERR never asserted.
- TYPE=1, FREQ=0x1000, STEP=0x10, RATE=3, Ti=9 -> FREQ_OUT = 0x1000, 0x1010, 0x1020 in 3-cycle steps within each impulse; restarts at 0x1000 on impulse 2.
- TYPE=2, N=3, STEP=0xFFFF_FFFF_FFFF, FREQ=2 -> impulse frequencies 2, 1, 0 (wrap-around).
- Load with TIME_START=50 at TIME=100 -> one-cycle LATE_ERR; sequence starts next cycle.
- Second DATA_WR during PULSE of cmd A -> A completes unchanged; REQ_COMM issued; then ARMED with cmd B; B executes at its TIME_START.
- N=0, and separately Tp=Ti=4 -> for N=0: REQ_COMM only, IMP never high. For Tp=Ti=4: period 5, gap 1. Assert rst_n=0 mid-PULSE -> IMP/BUSY/REQ_COMM 0 asynchronously.
